// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl_if : operand/result handshakes and adder-side bus
// Rev 1.0
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;

    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_c0;
    logic [3:0]   add_s;
    logic         add_c4;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    // The controller side; the external adder and up/downstream sit on master.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_s, add_c4, out_ready,
        output in_ready, add_a, add_b, add_c0, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_s, add_c4, out_ready,
        input  in_ready, add_a, add_b, add_c0, out_valid, out_sum, out_cout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl : streams W-bit operands one nibble per clock
// through an external 4-bit adder and returns the assembled sum.  Rev 1.0
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    nibble_serial_adder_ctrl_if.slave  bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;

    logic [IDX_W+1:0] w_base;
    logic             w_run;
    logic             w_last;

    assign w_base = {idx_q, 2'b00};
    assign w_run  = (state_q == S_RUN);
    assign w_last = (idx_q == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            sum_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[w_base +: 4] = bus.add_s;
                carry_d            = bus.add_c4;
                if (w_last) begin
                    // Result registers are separate from sum_q so they hold
                    // through the next transaction, which clears sum_q.
                    out_sum_d  = sum_d;
                    out_cout_d = bus.add_c4;
                    out_ovf_d  = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
                    state_d    = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;

    assign bus.add_a  = w_run ? a_q[w_base +: 4] : 4'h0;
    assign bus.add_b  = w_run ? b_q[w_base +: 4] : 4'h0;
    assign bus.add_c0 = w_run ? carry_q : 1'b0;

endmodule
`default_nettype wire
